// File: rtl/step_clock_pkg.sv
// rtl/step_clock_pkg.sv - shared types and constants for the step clock generator
package step_clock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REL = 2'd1,
        RUN      = 2'd2,
        HALTED   = 2'd3
    } state_t;

    // Free-run divisors on a 50 MHz clock: every cycle, 1 MHz, 1 kHz, 10 Hz.
    localparam int unsigned RATE_DIV0 = 1;
    localparam int unsigned RATE_DIV1 = 50;
    localparam int unsigned RATE_DIV2 = 50000;
    localparam int unsigned RATE_DIV3 = 5000000;

    // 20 ms of stable key level at 50 MHz.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

    function automatic int unsigned rate_div(input logic [1:0] sel);
        unique case (sel)
            2'd0: return RATE_DIV0;
            2'd1: return RATE_DIV1;
            2'd2: return RATE_DIV2;
            2'd3: return RATE_DIV3;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key synchronizer, debouncer and press edge detector
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   key_n        raw active-low push-button, asynchronous to clk
//   key_db       debounced key level, 1 = pressed
//   press_pulse  one-cycle pulse on the rising edge of key_db
module key_debounce
    import step_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_db,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       db_cnt;
    logic                   key_db_prev;
    logic                   pressed_raw;

    assign pressed_raw = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchronizer resets to the released level so no phantom press appears.
            sync_q      <= '1;
            db_cnt      <= '0;
            key_db      <= 1'b0;
            key_db_prev <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], key_n};
            key_db_prev <= key_db;
            // Any cycle where the raw level agrees with key_db restarts the window.
            if (pressed_raw != key_db) begin
                if (db_cnt == DB_LAST) begin
                    key_db <= ~key_db;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press_pulse = key_db & ~key_db_prev;

endmodule

// File: rtl/step_clock_gen.sv
// rtl/step_clock_gen.sv - single-step / free-run clock enable generator for the core
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   key_n        raw active-low step button
//   run_sw       1 = free-run, 0 = single-step
//   rate_sel     free-run divisor select
//   halt         core halted; suppresses stepping
//   step_en      registered one-cycle clock enable to the core
//   run_active   1 while in RUN
//   key_db       debounced key level
//   step_count   number of step_en pulses issued, wraps modulo 2^16
module step_clock_gen
    import step_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = 2,
    parameter int CNT_W           = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_n,
    input  logic        run_sw,
    input  logic [1:0]  rate_sel,
    input  logic        halt,
    output logic        step_en,
    output logic        run_active,
    output logic        key_db,
    output logic [15:0] step_count
);

    state_t           state, state_d;
    logic             press_pulse;
    logic             step_d;
    logic [1:0]       rate_sel_q;
    logic [CNT_W-1:0] rate_cnt, rate_cnt_d, cnt_eff, div_last;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES),
        .CNT_W          (CNT_W)
    ) u_key_debounce (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .key_db     (key_db),
        .press_pulse(press_pulse)
    );

    assign div_last = CNT_W'(rate_div(rate_sel) - 1);

    // A rate change restarts the count with the current cycle as count 0.
    assign cnt_eff = (rate_sel != rate_sel_q) ? '0 : rate_cnt;

    always_comb begin
        state_d    = state;
        step_d     = 1'b0;
        rate_cnt_d = '0;
        unique case (state)
            IDLE: begin
                if (halt)             state_d = HALTED;
                else if (run_sw)      state_d = RUN;
                else if (press_pulse) begin
                    step_d  = 1'b1;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (halt)         state_d = HALTED;
                else if (!key_db) state_d = IDLE;
            end
            RUN: begin
                if (halt)         state_d = HALTED;
                else if (!run_sw) state_d = IDLE;
                else if (cnt_eff == div_last) begin
                    step_d     = 1'b1;
                    rate_cnt_d = '0;
                end else begin
                    rate_cnt_d = cnt_eff + 1'b1;
                end
            end
            HALTED: begin
                // Always pass through IDLE so free-run resumes one cycle later.
                if (!halt) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rate_cnt   <= '0;
            rate_sel_q <= 2'd0;
            step_en    <= 1'b0;
            run_active <= 1'b0;
            step_count <= 16'd0;
        end else begin
            state      <= state_d;
            rate_cnt   <= rate_cnt_d;
            rate_sel_q <= rate_sel;
            step_en    <= step_d;
            run_active <= (state_d == RUN);
            step_count <= step_count + {15'd0, step_en};
        end
    end

endmodule
